// File: rtl/ysyx_22051468_dmem_responder_pkg.sv
// rtl/ysyx_22051468_dmem_responder_pkg.sv - shared FSM states, lane masks and lane helper for the data memory responder
package ysyx_22051468_dmem_responder_pkg;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_WAIT = 2'd1,
    ST_RESP = 2'd2
  } state_t;

  localparam logic [7:0] MASK_B = 8'h01;
  localparam logic [7:0] MASK_H = 8'h03;
  localparam logic [7:0] MASK_W = 8'h0F;
  localparam logic [7:0] MASK_D = 8'hFF;

  // Shifts a low-justified byte mask to its lane. The upper byte of the
  // result holds lanes pushed past the doubleword and flags a lane crossing.
  function automatic logic [15:0] lane_mask(input logic [7:0] mask, input logic [2:0] off);
    return {8'h00, mask} << off;
  endfunction

endpackage

// File: rtl/ysyx_22051468_dmem_array.sv
// rtl/ysyx_22051468_dmem_array.sv - single-port doubleword store with byte enables and registered read
// Ports:
//   clk      clock
//   i_en     port access this cycle (read and optional byte write)
//   i_addr   doubleword index
//   i_be     byte write enables, one per lane
//   i_wdata  lane-aligned write data
//   o_rdata  doubleword read at the last enabled edge (old contents); held while idle
module ysyx_22051468_dmem_array #(
  parameter int WIDTH      = 64,
  parameter int DEPTH_LOG2 = 12
) (
  input  logic                  clk,
  input  logic                  i_en,
  input  logic [DEPTH_LOG2-1:0] i_addr,
  input  logic [WIDTH/8-1:0]    i_be,
  input  logic [WIDTH-1:0]      i_wdata,
  output logic [WIDTH-1:0]      o_rdata
);

  logic [WIDTH-1:0] r_mem [2**DEPTH_LOG2];
  logic [WIDTH-1:0] r_q;

  always_ff @(posedge clk) begin
    if (i_en) begin
      for (int i = 0; i < WIDTH/8; i++) begin
        if (i_be[i]) begin
          r_mem[i_addr][8*i +: 8] <= i_wdata[8*i +: 8];
        end
      end
      r_q <= r_mem[i_addr];
    end
  end

  assign o_rdata = r_q;

endmodule

// File: rtl/ysyx_22051468_dmem_responder.sv
// rtl/ysyx_22051468_dmem_responder.sv - handshaked data memory responder for Exec/LSU load-store requests
// Ports:
//   clk, rst_n              clock, asynchronous active-low reset
//   req_valid/req_ready     request handshake (accepted only in IDLE)
//   req_we/addr/wdata/wmask store flag, byte address, low-justified data and mask
//   resp_valid/resp_ready   response handshake, response held until consumed
//   resp_rdata              aligned doubleword for loads, 0 for stores and faults
//   resp_err                access fault (out of range, or store crossing the doubleword)
module ysyx_22051468_dmem_responder
  import ysyx_22051468_dmem_responder_pkg::*;
#(
  parameter int          WIDTH      = 64,
  parameter int          DEPTH_LOG2 = 12,
  parameter logic [63:0] BASE_ADDR  = 64'h8000_0000,
  parameter int          LATENCY    = 1
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             req_valid,
  output logic             req_ready,
  input  logic             req_we,
  input  logic [63:0]      req_addr,
  input  logic [WIDTH-1:0] req_wdata,
  input  logic [7:0]       req_wmask,
  output logic             resp_valid,
  input  logic             resp_ready,
  output logic [WIDTH-1:0] resp_rdata,
  output logic             resp_err
);

  localparam logic [63:0] SPAN = 64'(8) << DEPTH_LOG2;

  state_t                r_state;
  state_t                w_next;
  logic [3:0]            r_cnt;
  logic                  r_we;
  logic [63:0]           r_addr;
  logic [WIDTH-1:0]      r_wdata;
  logic [7:0]            r_wmask;
  logic                  r_resp_err;
  logic                  r_resp_load;

  logic                  w_accept;
  logic                  w_commit;
  logic [2:0]            w_off;
  logic [63:0]           w_rel;
  logic                  w_in_range;
  logic [15:0]           w_lanes;
  logic                  w_err;
  logic [DEPTH_LOG2-1:0] w_idx;
  logic [7:0]            w_be;
  logic [WIDTH-1:0]      w_wdata_al;
  logic                  w_mem_en;
  logic [WIDTH-1:0]      w_mem_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state <= ST_IDLE;
    end else begin
      r_state <= w_next;
    end
  end

  // The last WAIT cycle (counter at 0) is the commit cycle, so a request
  // always spends LATENCY+1 cycles between accept and RESP.
  always_comb begin
    w_next     = r_state;
    req_ready  = 1'b0;
    resp_valid = 1'b0;
    w_commit   = 1'b0;
    case (r_state)
      ST_IDLE: begin
        req_ready = 1'b1;
        if (req_valid) w_next = ST_WAIT;
      end
      ST_WAIT: begin
        if (r_cnt == 4'd0) begin
          w_commit = 1'b1;
          w_next   = ST_RESP;
        end
      end
      ST_RESP: begin
        resp_valid = 1'b1;
        if (resp_ready) w_next = ST_IDLE;
      end
      default: w_next = ST_IDLE;
    endcase
  end

  assign w_accept = req_valid & req_ready;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_cnt       <= 4'd0;
      r_we        <= 1'b0;
      r_addr      <= '0;
      r_wdata     <= '0;
      r_wmask     <= '0;
      r_resp_err  <= 1'b0;
      r_resp_load <= 1'b0;
    end else begin
      if (w_accept) begin
        r_we    <= req_we;
        r_addr  <= req_addr;
        r_wdata <= req_wdata;
        r_wmask <= req_wmask;
        r_cnt   <= 4'(LATENCY);
      end else if (r_state == ST_WAIT && r_cnt != 4'd0) begin
        r_cnt <= r_cnt - 4'd1;
      end
      if (w_commit) begin
        r_resp_err  <= w_err;
        r_resp_load <= ~r_we & ~w_err;
      end
    end
  end

  assign w_off      = r_addr[2:0];
  assign w_rel      = r_addr - BASE_ADDR;
  assign w_in_range = (r_addr >= BASE_ADDR) && (w_rel < SPAN);
  assign w_lanes    = lane_mask(r_wmask, w_off);
  assign w_err      = ~w_in_range | (r_we & (|w_lanes[15:8]));
  assign w_idx      = w_rel[DEPTH_LOG2+2:3];
  assign w_be       = r_we ? w_lanes[7:0] : 8'h00;
  assign w_wdata_al = r_wdata << {w_off, 3'b000};
  // Faulting accesses never touch the array, so a crossing store writes nothing.
  assign w_mem_en   = w_commit & ~w_err;

  ysyx_22051468_dmem_array #(
    .WIDTH      (WIDTH),
    .DEPTH_LOG2 (DEPTH_LOG2)
  ) u_array (
    .clk     (clk),
    .i_en    (w_mem_en),
    .i_addr  (w_idx),
    .i_be    (w_be),
    .i_wdata (w_wdata_al),
    .o_rdata (w_mem_q)
  );

  // Array read data is captured at the commit edge and held by the idle port.
  assign resp_rdata = (r_state == ST_RESP && r_resp_load) ? w_mem_q : '0;
  assign resp_err   = r_resp_err;

endmodule

// File: tb/tb_ysyx_22051468_dmem_responder.sv
// tb/tb_ysyx_22051468_dmem_responder.sv - self-checking bench for the data memory responder
module tb_ysyx_22051468_dmem_responder;
  import ysyx_22051468_dmem_responder_pkg::*;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        rst3_n = 1'b0;
  logic        t_we = 1'b0;
  logic [63:0] t_addr = '0;
  logic [63:0] t_wdata = '0;
  logic [7:0]  t_wmask = '0;
  logic        v1 = 1'b0, v3 = 1'b0, v0 = 1'b0;
  logic        a1 = 1'b0, a3 = 1'b0, a0 = 1'b0;
  logic        rr1, rr3, rr0, rv1, rv3, rv0, er1, er3, er0;
  logic [63:0] rd1, rd3, rd0;
  int          cur = 0;
  int          n_cmp = 0;
  int          n_fail = 0;

  logic        s_req_ready, s_resp_valid, s_resp_err;
  logic [63:0] s_resp_rdata;

  byte unsigned mdl [logic [63:0]];

  always #5 clk = ~clk;

  ysyx_22051468_dmem_responder #(.LATENCY(1)) dut1 (
    .clk(clk), .rst_n(rst_n), .req_valid(v1), .req_ready(rr1), .req_we(t_we),
    .req_addr(t_addr), .req_wdata(t_wdata), .req_wmask(t_wmask),
    .resp_valid(rv1), .resp_ready(a1), .resp_rdata(rd1), .resp_err(er1));

  ysyx_22051468_dmem_responder #(.LATENCY(3)) dut3 (
    .clk(clk), .rst_n(rst3_n), .req_valid(v3), .req_ready(rr3), .req_we(t_we),
    .req_addr(t_addr), .req_wdata(t_wdata), .req_wmask(t_wmask),
    .resp_valid(rv3), .resp_ready(a3), .resp_rdata(rd3), .resp_err(er3));

  ysyx_22051468_dmem_responder #(.LATENCY(0)) dut0 (
    .clk(clk), .rst_n(rst_n), .req_valid(v0), .req_ready(rr0), .req_we(t_we),
    .req_addr(t_addr), .req_wdata(t_wdata), .req_wmask(t_wmask),
    .resp_valid(rv0), .resp_ready(a0), .resp_rdata(rd0), .resp_err(er0));

  assign s_req_ready  = (cur == 0) ? rr1 : (cur == 1) ? rr3 : rr0;
  assign s_resp_valid = (cur == 0) ? rv1 : (cur == 1) ? rv3 : rv0;
  assign s_resp_rdata = (cur == 0) ? rd1 : (cur == 1) ? rd3 : rd0;
  assign s_resp_err   = (cur == 0) ? er1 : (cur == 1) ? er3 : er0;

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic set_valid(input int s, input logic v);
    if (s == 0) v1 = v; else if (s == 1) v3 = v; else v0 = v;
  endtask

  task automatic set_ack(input int s, input logic v);
    if (s == 0) a1 = v; else if (s == 1) a3 = v; else a0 = v;
  endtask

  function automatic int lat_of(input int s);
    return (s == 0) ? 1 : (s == 1) ? 3 : 0;
  endfunction

  // One full transaction; checks latency, response contents, stability while
  // the response is held, and the return to IDLE after it is consumed.
  task automatic xfer(input string tag, input int s, input logic we, input logic [63:0] a,
                      input logic [63:0] d, input logic [7:0] m, input int hold,
                      input logic [63:0] exp_rd, input logic exp_er);
    int k;
    cur = s;
    @(negedge clk);
    t_we = we; t_addr = a; t_wdata = d; t_wmask = m;
    set_valid(s, 1'b1);
    k = 0;
    while (!s_req_ready && k < 20) begin @(negedge clk); k++; end
    check({tag, "_req_ready"}, 64'(s_req_ready), 64'd1);
    @(negedge clk);
    set_valid(s, 1'b0);
    k = 0;
    while (!s_resp_valid && k < 40) begin @(negedge clk); k++; end
    check({tag, "_latency"}, 64'(k), 64'(lat_of(s) + 1));
    check({tag, "_rdata"}, s_resp_rdata, exp_rd);
    check({tag, "_err"}, 64'(s_resp_err), 64'(exp_er));
    for (int h = 0; h < hold; h++) begin
      @(negedge clk);
      check({tag, "_hold_valid"}, 64'(s_resp_valid), 64'd1);
      check({tag, "_hold_rdata"}, s_resp_rdata, exp_rd);
      check({tag, "_hold_ready"}, 64'(s_req_ready), 64'd0);
    end
    set_ack(s, 1'b1);
    @(negedge clk);
    set_ack(s, 1'b0);
    check({tag, "_done_valid"}, 64'(s_resp_valid), 64'd0);
    check({tag, "_done_ready"}, 64'(s_req_ready), 64'd1);
  endtask

  function automatic int nbytes(input logic [7:0] m);
    int n = 0;
    for (int i = 0; i < 8; i++) if (m[i]) n++;
    return n;
  endfunction

  function automatic logic mdl_in_range(input logic [63:0] a);
    return (a >= 64'h8000_0000) && (a < 64'h8000_8000);
  endfunction

  function automatic logic [63:0] mdl_load(input logic [63:0] a);
    logic [63:0] base = {a[63:3], 3'b000};
    logic [63:0] v = '0;
    for (int b = 0; b < 8; b++) v[8*b +: 8] = mdl[base + 64'(b)];
    return v;
  endfunction

  // Reference access for dut1: byte-addressed memory, size from mask popcount.
  task automatic ref_xfer(input string tag, input logic we, input logic [63:0] a,
                          input logic [63:0] d, input logic [7:0] m, input int hold);
    logic err;
    logic [63:0] exp_rd;
    err = !mdl_in_range(a) || (we && (int'(a[2:0]) + nbytes(m) > 8));
    exp_rd = '0;
    if (!err && we) begin
      for (int b = 0; b < nbytes(m); b++) mdl[a + 64'(b)] = d[8*b +: 8];
    end
    if (!err && !we) exp_rd = mdl_load(a);
    xfer(tag, 0, we, a, d, m, hold, exp_rd, err);
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog timeout");
    $fatal(1, "timeout");
  end

  initial begin
    logic [63:0] a, d;
    logic [7:0]  m;
    logic        we;

    repeat (3) @(negedge clk);
    check("rst_resp_valid", 64'(rv1), 64'd0);
    check("rst_req_ready", 64'(rr1), 64'd1);
    check("rst_rdata", rd1, 64'd0);
    check("rst_err", 64'(er1), 64'd0);
    rst_n = 1'b1;
    rst3_n = 1'b1;

    ref_xfer("t1_sd", 1'b1, 64'h8000_0010, 64'h1122334455667788, MASK_D, 0);
    xfer("t1_ld", 0, 1'b0, 64'h8000_0010, 64'h0, MASK_D, 1, 64'h1122334455667788, 1'b0);

    ref_xfer("t2_sw", 1'b1, 64'h8000_0014, 64'hDEADBEEF, MASK_W, 0);
    ref_xfer("t2_sb", 1'b1, 64'h8000_0017, 64'hAB, MASK_B, 0);
    xfer("t2_ld", 0, 1'b0, 64'h8000_0010, 64'h0, MASK_D, 0, 64'hABADBEEF55667788, 1'b0);

    xfer("t3_sh", 0, 1'b1, 64'h8000_0017, 64'h1234, MASK_H, 0, 64'h0, 1'b1);
    xfer("t3_ld", 0, 1'b0, 64'h8000_0010, 64'h0, MASK_D, 0, 64'hABADBEEF55667788, 1'b0);

    xfer("t4_lo", 0, 1'b0, 64'h7FFF_FFF8, 64'h0, MASK_D, 0, 64'h0, 1'b1);
    xfer("t4_hi", 0, 1'b0, 64'h8000_8000, 64'h0, MASK_D, 0, 64'h0, 1'b1);

    xfer("t5_sd3", 1, 1'b1, 64'h8000_0020, 64'h0123456789ABCDEF, MASK_D, 0, 64'h0, 1'b0);
    xfer("t5_ld3", 1, 1'b0, 64'h8000_0023, 64'h0, MASK_D, 5, 64'h0123456789ABCDEF, 1'b0);
    xfer("t5_sd0", 2, 1'b1, 64'h8000_0008, 64'hCAFEF00D12345678, MASK_D, 0, 64'h0, 1'b0);
    xfer("t5_ld0", 2, 1'b0, 64'h8000_0008, 64'h0, MASK_D, 2, 64'hCAFEF00D12345678, 1'b0);

    cur = 1;
    @(negedge clk);
    t_we = 1'b1; t_addr = 64'h8000_0020; t_wdata = '1; t_wmask = MASK_D;
    v3 = 1'b1;
    @(negedge clk);
    v3 = 1'b0;
    @(negedge clk);
    rst3_n = 1'b0;
    #1;
    check("t6_rst_valid", 64'(rv3), 64'd0);
    check("t6_rst_ready", 64'(rr3), 64'd1);
    repeat (5) @(negedge clk);
    check("t6_rst_hold", 64'(rv3), 64'd0);
    rst3_n = 1'b1;
    xfer("t6_ld", 1, 1'b0, 64'h8000_0020, 64'h0, MASK_D, 0, 64'h0123456789ABCDEF, 1'b0);

    for (int i = 0; i < 32; i++) begin
      ref_xfer("init", 1'b1, 64'h8000_0000 + 64'(8 * i), {$urandom, $urandom}, MASK_D, 0);
    end

    for (int i = 0; i < 80; i++) begin
      we = 1'($urandom_range(0, 1));
      case ($urandom_range(0, 3))
        0: m = MASK_B;
        1: m = MASK_H;
        2: m = MASK_W;
        default: m = MASK_D;
      endcase
      d = {$urandom, $urandom};
      case ($urandom_range(0, 9))
        0: a = 64'h7FFF_FF00 + 64'($urandom_range(0, 255));
        1: a = 64'h8000_8000 + 64'($urandom_range(0, 255));
        default: a = 64'h8000_0000 + 64'($urandom_range(0, 255));
      endcase
      ref_xfer("rand", we, a, d, m, $urandom_range(0, 2));
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
